// File: rtl/udp_10g_pkg.sv
// Shared constants and FSM encoding for the 10G UDP transmit/receive paths.
package udp_10g_pkg;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam int          UDP_PAD_BYTES = 6;
  localparam int          UDP_HDR_BYTES = 8;
  localparam int          HDR_WORDS     = 6;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    HEAD = 4'b0010,
    DATA = 4'b0100,
    DROP = 4'b1000
  } state_t;

  // Two end-around-carry folds bring any 32-bit lane sum into 16 bits.
  function automatic logic [15:0] fold32(input logic [31:0] s);
    logic [16:0] t;
    logic [15:0] u;
    t = {1'b0, s[31:16]} + {1'b0, s[15:0]};
    u = t[15:0] + 16'(t[16]);
    return u;
  endfunction
endpackage

// File: rtl/ip_hdr_csum_chk.sv
// IPv4 header one's-complement accumulator: adds the enabled 16-bit lanes of each
// strobed word; a valid header folds to FFFF.
module ip_hdr_csum_chk
  import udp_10g_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        strobe,
  input  logic [63:0] data,
  input  logic [3:0]  lane_en,
  output logic [15:0] sum_folded,
  output logic        ok
);
  logic [31:0] acc;
  logic [31:0] lane_sum;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < 4; i++)
      if (lane_en[i]) lane_sum = lane_sum + 32'(data[16*i +: 16]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc <= '0;
    else if (clr)    acc <= '0;
    else if (strobe) acc <= acc + lane_sum;
  end

  assign sum_folded = fold32(acc);
  assign ok         = (sum_folded == 16'hFFFF);
endmodule

// File: rtl/udp_recv_from_10gmac.sv
// 10G MAC RX -> UDP payload FIFO: header parse/filter, pad strip, per-frame status.
module udp_recv_from_10gmac
  import udp_10g_pkg::*;
#(
  parameter logic [15:0] LOCAL_UDP_PORT = 16'h1F90,
  parameter bit          CHECK_IP_CSUM  = 1'b1
) (
  input  logic        clk_156_25,
  input  logic        rst_n,
  input  logic [63:0] avalon_st_rx_data,
  input  logic        avalon_st_rx_valid,
  input  logic        avalon_st_rx_startofpacket,
  input  logic        avalon_st_rx_endofpacket,
  input  logic [2:0]  avalon_st_rx_empty,
  input  logic [5:0]  avalon_st_rx_error,
  output logic        avalon_st_rx_ready,
  input  logic [47:0] local_mac_addr,
  input  logic [31:0] local_ip_addr,
  output logic        wr_req,
  output logic [63:0] wr_data,
  output logic        wr_last,
  input  logic        fifo_almost_full,
  output logic        rx_done,
  output logic        rx_error,
  output logic [15:0] rx_data_length,
  output logic [47:0] rx_src_mac,
  output logic [31:0] rx_src_ip
);
  state_t      state, nxt;
  logic        beat, sop, eop, sop_beat;
  logic [2:0]  cnt;
  logic [15:0] remaining, len_q;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] eth_type, ip_total, udp_dst, udp_len;
  logic [7:0]  ver_ihl, proto;
  logic [31:0] dst_ip, src_ip;
  logic [3:0]  lane_en;
  logic [15:0] csum_folded;
  logic        csum_ok, mac_ok, len_ok, frame_ok;
  logic        do_wr, do_last, do_done, do_err, accept;

  assign avalon_st_rx_ready = ~fifo_almost_full;
  assign beat     = avalon_st_rx_valid & avalon_st_rx_ready;
  assign sop      = avalon_st_rx_startofpacket;
  assign eop      = avalon_st_rx_endofpacket;
  assign sop_beat = beat & sop;

  // IP header occupies lane 0 of w1, all of w2/w3, lane 3 of w4.
  always_comb begin
    case (cnt)
      3'd1:       lane_en = 4'b0001;
      3'd2, 3'd3: lane_en = 4'b1111;
      3'd4:       lane_en = 4'b1000;
      default:    lane_en = 4'b0000;
    endcase
  end

  ip_hdr_csum_chk u_csum (
    .clk        (clk_156_25),
    .rst_n      (rst_n),
    .clr        (sop_beat),
    .strobe     (beat && state == HEAD && !sop),
    .data       (avalon_st_rx_data),
    .lane_en    (lane_en),
    .sum_folded (csum_folded),
    .ok         (csum_ok)
  );

  assign mac_ok   = (dst_mac == local_mac_addr) || (dst_mac == '1);
  assign len_ok   = (udp_len >= 16'd15) && ({1'b0, ip_total} == ({1'b0, udp_len} + 17'd20));
  assign frame_ok = (eth_type == ETH_TYPE_IPV4) && (ver_ihl == IP_VER_IHL) &&
                    (proto == IP_PROTO_UDP) && mac_ok && (dst_ip == local_ip_addr) &&
                    (udp_dst == LOCAL_UDP_PORT) && len_ok && (!CHECK_IP_CSUM || csum_ok);

  always_ff @(posedge clk_156_25 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    do_wr   = 1'b0;
    do_last = 1'b0;
    do_done = 1'b0;
    do_err  = 1'b0;
    accept  = 1'b0;
    if (beat) begin
      case (state)
        IDLE: if (sop && !eop) nxt = HEAD;
        HEAD: begin
          if (sop)       nxt = eop ? IDLE : HEAD;
          else if (eop)  nxt = IDLE;
          else if (cnt == 3'(HDR_WORDS - 1)) begin
            accept = frame_ok;
            nxt    = frame_ok ? DATA : DROP;
          end
        end
        DATA: begin
          if (sop) begin
            // Abort: close the old frame without writing the new SOP word.
            do_last = 1'b1;
            do_done = 1'b1;
            do_err  = 1'b1;
            nxt     = eop ? IDLE : HEAD;
          end else begin
            do_wr = 1'b1;
            if (remaining <= 16'd8) begin
              do_last = 1'b1;
              do_done = 1'b1;
              do_err  = eop & (|avalon_st_rx_error);
              nxt     = eop ? IDLE : DROP;
            end else if (eop) begin
              do_last = 1'b1;
              do_done = 1'b1;
              do_err  = 1'b1;
              nxt     = IDLE;
            end
          end
        end
        DROP: begin
          if (sop)      nxt = eop ? IDLE : HEAD;
          else if (eop) nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_156_25 or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dst_mac  <= '0;
      src_mac  <= '0;
      eth_type <= '0;
      ver_ihl  <= '0;
      ip_total <= '0;
      proto    <= '0;
      src_ip   <= '0;
      dst_ip   <= '0;
      udp_dst  <= '0;
      udp_len  <= '0;
    end else if (sop_beat) begin
      cnt           <= 3'd1;
      dst_mac       <= avalon_st_rx_data[63:16];
      src_mac[47:32] <= avalon_st_rx_data[15:0];
    end else if (beat && state == HEAD) begin
      cnt <= cnt + 3'd1;
      case (cnt)
        3'd1: begin
          src_mac[31:0] <= avalon_st_rx_data[63:32];
          eth_type      <= avalon_st_rx_data[31:16];
          ver_ihl       <= avalon_st_rx_data[15:8];
        end
        3'd2: begin
          ip_total <= avalon_st_rx_data[63:48];
          proto    <= avalon_st_rx_data[7:0];
        end
        3'd3: begin
          src_ip        <= avalon_st_rx_data[47:16];
          dst_ip[31:16] <= avalon_st_rx_data[15:0];
        end
        3'd4: begin
          dst_ip[15:0] <= avalon_st_rx_data[63:48];
          udp_dst      <= avalon_st_rx_data[31:16];
          udp_len      <= avalon_st_rx_data[15:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_156_25 or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      len_q     <= '0;
    end else if (accept) begin
      remaining <= udp_len - 16'(UDP_HDR_BYTES + UDP_PAD_BYTES);
      len_q     <= udp_len - 16'(UDP_HDR_BYTES + UDP_PAD_BYTES);
    end else if (beat && state == DATA) begin
      remaining <= remaining - 16'd8;
    end
  end

  always_ff @(posedge clk_156_25 or negedge rst_n) begin
    if (!rst_n) begin
      wr_req         <= 1'b0;
      wr_data        <= '0;
      wr_last        <= 1'b0;
      rx_done        <= 1'b0;
      rx_error       <= 1'b0;
      rx_data_length <= '0;
      rx_src_mac     <= '0;
      rx_src_ip      <= '0;
    end else begin
      wr_req   <= do_wr;
      wr_last  <= do_last;
      rx_done  <= do_done;
      rx_error <= do_err;
      if (do_wr) wr_data <= avalon_st_rx_data;
      if (do_done) begin
        rx_data_length <= len_q;
        rx_src_mac     <= src_mac;
        rx_src_ip      <= src_ip;
      end
    end
  end

  // Payload length comes from the UDP header, so the MAC empty count is not needed.
  logic unused_ok;
  assign unused_ok = ^{avalon_st_rx_empty, csum_folded};
endmodule

// File: tb/tb_udp_recv_from_10gmac.sv
// Scoreboard bench for udp_recv_from_10gmac: directed frames, queue-based expected writes/status.
`timescale 1ns/1ps
module tb_udp_recv_from_10gmac;
  import udp_10g_pkg::*;

  localparam logic [47:0] LOCAL_MAC = 48'h001B21AABBCC;
  localparam logic [31:0] LOCAL_IP  = 32'hC0A8010A;
  localparam logic [47:0] SRC_MAC   = 48'h021122334455;
  localparam logic [31:0] SRC_IP    = 32'hC0A80102;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] rx_data;
  logic        rx_valid, rx_sop, rx_eop;
  logic [2:0]  rx_empty;
  logic [5:0]  rx_err;
  logic        avalon_st_rx_ready;
  logic        wr_req, wr_last, fifo_almost_full;
  logic [63:0] wr_data;
  logic        rx_done, rx_error;
  logic [15:0] rx_data_length;
  logic [47:0] rx_src_mac;
  logic [31:0] rx_src_ip;

  always #3 clk = ~clk;

  udp_recv_from_10gmac dut (
    .clk_156_25                 (clk),
    .rst_n                      (rst_n),
    .avalon_st_rx_data          (rx_data),
    .avalon_st_rx_valid         (rx_valid),
    .avalon_st_rx_startofpacket (rx_sop),
    .avalon_st_rx_endofpacket   (rx_eop),
    .avalon_st_rx_empty         (rx_empty),
    .avalon_st_rx_error         (rx_err),
    .avalon_st_rx_ready         (avalon_st_rx_ready),
    .local_mac_addr             (LOCAL_MAC),
    .local_ip_addr              (LOCAL_IP),
    .wr_req                     (wr_req),
    .wr_data                    (wr_data),
    .wr_last                    (wr_last),
    .fifo_almost_full           (fifo_almost_full),
    .rx_done                    (rx_done),
    .rx_error                   (rx_error),
    .rx_data_length             (rx_data_length),
    .rx_src_mac                 (rx_src_mac),
    .rx_src_ip                  (rx_src_ip)
  );

  typedef struct { logic [63:0] data; logic last; } wr_t;
  typedef struct { logic err; logic [15:0] len; logic [47:0] mac; logic [31:0] ip; logic wrq; } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  wr_t   ew;
  done_t ed;
  logic [7:0] fb[$];
  int tests = 0, fails = 0, wr_seen = 0, ws;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm, input logic [63:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %h expected no output", nm, act);
  endtask

  // Monitor: every write / status pulse is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_req) begin
        wr_seen++;
        if (exp_wr.size() == 0) bad("unexpected_wr", wr_data);
        else begin
          ew = exp_wr.pop_front();
          chk("wr_data", wr_data, ew.data);
          chk("wr_last", 64'(wr_last), 64'(ew.last));
        end
      end
      if (rx_done) begin
        if (exp_done.size() == 0) bad("unexpected_done", 64'(rx_data_length));
        else begin
          ed = exp_done.pop_front();
          chk("rx_error", 64'(rx_error), 64'(ed.err));
          chk("rx_data_length", 64'(rx_data_length), 64'(ed.len));
          chk("rx_src_mac", 64'(rx_src_mac), 64'(ed.mac));
          chk("rx_src_ip", 64'(rx_src_ip), 64'(ed.ip));
          chk("done_wr_req", 64'(wr_req), 64'(ed.wrq));
          chk("done_wr_last", 64'(wr_last), 64'd1);
        end
      end else if (wr_last && !wr_req) bad("stray_wr_last", 64'(wr_last));
    end
  end

  task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [31:0] dip,
                       input logic [15:0] dport, input int n, input bit bad_csum, input logic [7:0] seed);
    logic [7:0]  ip [20];
    logic [15:0] ulen, tot, cs;
    logic [31:0] s;
    ulen = 16'(n + 14);
    tot  = ulen + 16'd20;
    ip[0] = 8'h45; ip[1] = 8'h00; ip[2] = tot[15:8]; ip[3] = tot[7:0];
    ip[4] = 8'h12; ip[5] = 8'h34; ip[6] = 8'h40; ip[7] = 8'h00;
    ip[8] = 8'h40; ip[9] = 8'h11; ip[10] = 8'h00; ip[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      ip[12+i] = SRC_IP[31-8*i -: 8];
      ip[16+i] = dip[31-8*i -: 8];
    end
    s = '0;
    for (int i = 0; i < 10; i++) s = s + {16'h0, ip[2*i], ip[2*i+1]};
    s = {16'h0, s[31:16]} + {16'h0, s[15:0]};
    s = {16'h0, s[31:16]} + {16'h0, s[15:0]};
    cs = ~s[15:0];
    ip[10] = cs[15:8];
    ip[11] = cs[7:0] ^ (bad_csum ? 8'h01 : 8'h00);
    fb.delete();
    for (int i = 0; i < 6; i++) fb.push_back(dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(SRC_MAC[47-8*i -: 8]);
    fb.push_back(etype[15:8]); fb.push_back(etype[7:0]);
    for (int i = 0; i < 20; i++) fb.push_back(ip[i]);
    fb.push_back(8'h04); fb.push_back(8'hD2);
    fb.push_back(dport[15:8]); fb.push_back(dport[7:0]);
    fb.push_back(ulen[15:8]); fb.push_back(ulen[7:0]);
    fb.push_back(8'h00); fb.push_back(8'h00);
    for (int i = 0; i < 6; i++) fb.push_back(8'h00);
    for (int i = 0; i < n; i++) fb.push_back(seed + 8'(i));
    while (fb.size() < 64) fb.push_back(8'h00);
  endtask

  task automatic send_word(input logic [63:0] d, input logic s, input logic e,
                           input logic [2:0] emp, input logic [5:0] er);
    int guard;
    rx_data = d; rx_sop = s; rx_eop = e; rx_empty = emp; rx_err = er; rx_valid = 1'b1;
    guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (!avalon_st_rx_ready && guard < 200);
    if (guard >= 200) begin
      fails++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
    end
    #1;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_empty = '0; rx_err = '0;
  endtask

  task automatic send_frame(input int nsend, input bit eop_last, input logic [5:0] er);
    int nw, idx;
    logic [63:0] d;
    logic e;
    nw = (fb.size() + 7) / 8;
    if (nsend == 0) nsend = nw;
    for (int w = 0; w < nsend; w++) begin
      d = '0;
      for (int j = 0; j < 8; j++) begin
        idx = 8*w + j;
        if (idx < fb.size()) d[63-8*j -: 8] = fb[idx];
      end
      e = eop_last && (w == nsend - 1);
      send_word(d, w == 0, e, (e && nsend == nw) ? 3'((8 - fb.size() % 8) % 8) : 3'd0,
                e ? er : 6'd0);
    end
  endtask

  task automatic expect_frame(input int n, input logic [7:0] seed, input int nw, input bit last_fin,
                              input logic err, input logic wrq);
    wr_t w;
    done_t dn;
    int idx;
    for (int k = 0; k < nw; k++) begin
      w.data = '0;
      for (int j = 0; j < 8; j++) begin
        idx = 8*k + j;
        if (idx < n) w.data[63-8*j -: 8] = seed + 8'(idx);
      end
      w.last = last_fin && (k == nw - 1);
      exp_wr.push_back(w);
    end
    dn.err = err; dn.len = 16'(n); dn.mac = SRC_MAC; dn.ip = SRC_IP; dn.wrq = wrq;
    exp_done.push_back(dn);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    rx_empty = '0; rx_err = '0; fifo_almost_full = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("rst_wr_req", 64'(wr_req), 64'd0);
    chk("rst_wr_last", 64'(wr_last), 64'd0);
    chk("rst_rx_done", 64'(rx_done), 64'd0);
    chk("rst_rx_len", 64'(rx_data_length), 64'd0);
    chk("rst_src_mac", 64'(rx_src_mac), 64'd0);
    chk("rst_ready", 64'(avalon_st_rx_ready), 64'd1);

    // Loopback frame, 100 payload bytes
    ws = wr_seen;
    expect_frame(100, 8'h10, 13, 1, 1'b0, 1'b1);
    build(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'h1F90, 100, 0, 8'h10);
    send_frame(0, 1, 6'd0);
    idle(4);
    chk("t100_wr_count", 64'(wr_seen - ws), 64'd13);

    // 4-byte payload in a padded 64-byte frame
    ws = wr_seen;
    expect_frame(4, 8'hA0, 1, 1, 1'b0, 1'b1);
    build(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'h1F90, 4, 0, 8'hA0);
    send_frame(0, 1, 6'd0);
    idle(4);
    chk("t4_wr_count", 64'(wr_seen - ws), 64'd1);

    // Filtered frames: bad checksum, wrong port, wrong IP, ARP type
    ws = wr_seen;
    build(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'h1F90, 20, 1, 8'h30);  send_frame(0, 1, 6'd0);
    build(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'h1F91, 20, 0, 8'h30);  send_frame(0, 1, 6'd0);
    build(LOCAL_MAC, 16'h0800, 32'hC0A8010B, 16'h1F90, 20, 0, 8'h30); send_frame(0, 1, 6'd0);
    build(LOCAL_MAC, 16'h0806, LOCAL_IP, 16'h1F90, 20, 0, 8'h30);  send_frame(0, 1, 6'd0);
    idle(4);
    chk("drop_wr_count", 64'(wr_seen - ws), 64'd0);

    // Good frame after drops, then broadcast destination
    ws = wr_seen;
    expect_frame(20, 8'h50, 3, 1, 1'b0, 1'b1);
    build(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'h1F90, 20, 0, 8'h50);  send_frame(0, 1, 6'd0);
    expect_frame(16, 8'h60, 2, 1, 1'b0, 1'b1);
    build(48'hFFFFFFFFFFFF, 16'h0800, LOCAL_IP, 16'h1F90, 16, 0, 8'h60); send_frame(0, 1, 6'd0);
    idle(4);
    chk("good_bcast_wr_count", 64'(wr_seen - ws), 64'd5);

    // MAC error flagged on the EOP word
    expect_frame(24, 8'h70, 3, 1, 1'b1, 1'b1);
    build(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'h1F90, 24, 0, 8'h70);
    send_frame(0, 1, 6'h02);
    idle(4);

    // Back-pressure for 20 cycles mid-payload
    ws = wr_seen;
    expect_frame(100, 8'h80, 13, 1, 1'b0, 1'b1);
    build(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'h1F90, 100, 0, 8'h80);
    fork
      send_frame(0, 1, 6'd0);
      begin
        repeat (12) @(negedge clk);
        fifo_almost_full = 1'b1;
        repeat (20) begin
          @(negedge clk);
          chk("stall_ready", 64'(avalon_st_rx_ready), 64'd0);
          chk("stall_wr_req", 64'(wr_req), 64'd0);
        end
        fifo_almost_full = 1'b0;
      end
    join
    idle(4);
    chk("stall_wr_count", 64'(wr_seen - ws), 64'd13);

    // Truncated: EOP after 3 payload words
    ws = wr_seen;
    expect_frame(100, 8'h90, 3, 1, 1'b1, 1'b1);
    build(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'h1F90, 100, 0, 8'h90);
    send_frame(9, 1, 6'd0);
    idle(4);
    chk("trunc_wr_count", 64'(wr_seen - ws), 64'd3);

    // Abort: new SOP after 2 payload words, new frame received
    expect_frame(100, 8'hB0, 2, 0, 1'b1, 1'b0);
    build(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'h1F90, 100, 0, 8'hB0);
    send_frame(8, 0, 6'd0);
    expect_frame(16, 8'hC0, 2, 1, 1'b0, 1'b1);
    build(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'h1F90, 16, 0, 8'hC0);
    send_frame(0, 1, 6'd0);
    idle(4);

    // Reset while the third payload write is in flight
    for (int k = 0; k < 2; k++) begin
      ew.data = '0;
      for (int j = 0; j < 8; j++) ew.data[63-8*j -: 8] = 8'hD0 + 8'(8*k + j);
      ew.last = 1'b0;
      exp_wr.push_back(ew);
    end
    build(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'h1F90, 100, 0, 8'hD0);
    send_frame(9, 0, 6'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_req", 64'(wr_req), 64'd0);
    chk("mid_rst_wr_data", wr_data, 64'd0);
    chk("mid_rst_rx_len", 64'(rx_data_length), 64'd0);
    chk("mid_rst_src_ip", 64'(rx_src_ip), 64'd0);
    chk("mid_rst_state", 64'(dut.state), 64'(IDLE));
    idle(2);
    rst_n = 1'b1;
    idle(1);
    expect_frame(8, 8'hE0, 1, 1, 1'b0, 1'b1);
    build(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'h1F90, 8, 0, 8'hE0);
    send_frame(0, 1, 6'd0);
    idle(6);

    chk("wr_queue_left", 64'(exp_wr.size()), 64'd0);
    chk("done_queue_left", 64'(exp_done.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
